// File: rtl/serial_feeder.sv
// Buffers parallel words in a small FIFO and shifts them out one bit per clock.
// Latency: a word pushed into an empty, idle block shows its first bit two edges later.
// Backpressure: load_ready drops while the FIFO is full or flush is high; the serial side never stalls.
module serial_feeder #(
    parameter int   DATA_WIDTH = 8,
    parameter int   DEPTH      = 4,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_VALUE = 1'b0
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [DATA_WIDTH-1:0]        load_data,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic                         flush,
    output logic                         serial_out,
    output logic                         serial_active,
    output logic                         word_done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;

    logic                  push;
    logic                  pop;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] head;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign load_ready = (fifo_count < CNT_W'(DEPTH)) && !flush;
    assign push       = load_valid && load_ready;
    assign last_bit   = (state == ST_SHIFT) && (bit_cnt == BIT_W'(DATA_WIDTH-1));
    // Pop decision uses the pre-edge count, so a word just pushed waits one edge.
    assign pop        = !flush && (fifo_count != '0) && ((state == ST_IDLE) || last_bit);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // shreg always holds the bits not yet presented, next bit at the shift-out end.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            serial_out    <= IDLE_VALUE;
            serial_active <= 1'b0;
            word_done     <= 1'b0;
        end else if (flush) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            serial_out    <= IDLE_VALUE;
            serial_active <= 1'b0;
            word_done     <= 1'b0;
        end else if (pop) begin
            state         <= ST_SHIFT;
            shreg         <= advance(head);
            bit_cnt       <= '0;
            serial_out    <= first_bit(head);
            serial_active <= 1'b1;
            word_done     <= 1'b0;
        end else if ((state == ST_SHIFT) && !last_bit) begin
            shreg         <= advance(shreg);
            bit_cnt       <= bit_cnt + 1'b1;
            serial_out    <= first_bit(shreg);
            serial_active <= 1'b1;
            word_done     <= (bit_cnt == BIT_W'(DATA_WIDTH-2));
        end else if (last_bit) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            serial_out    <= IDLE_VALUE;
            serial_active <= 1'b0;
            word_done     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// Self-checking bench: a schedule-based model predicts each word's bit window from its push edge.
module tb_serial_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic          n_rst;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic          load_ready;
    logic          flush;
    logic          serial_out;
    logic          serial_active;
    logic          word_done;
    logic [CW-1:0] fifo_count;

    logic [DW-1:0] l_load_data;
    logic          l_load_valid;
    logic          l_load_ready;
    logic          l_flush;
    logic          l_serial_out;
    logic          l_serial_active;
    logic          l_word_done;
    logic [CW-1:0] l_fifo_count;

    serial_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MSB_FIRST(1), .IDLE_VALUE(1'b0)) dut (
        .clk(tb_clk), .n_rst(n_rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .flush(flush), .serial_out(serial_out),
        .serial_active(serial_active), .word_done(word_done), .fifo_count(fifo_count)
    );

    serial_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MSB_FIRST(0), .IDLE_VALUE(1'b0)) dut_lsb (
        .clk(tb_clk), .n_rst(n_rst), .load_data(l_load_data), .load_valid(l_load_valid),
        .load_ready(l_load_ready), .flush(l_flush), .serial_out(l_serial_out),
        .serial_active(l_serial_active), .word_done(l_word_done), .fifo_count(l_fifo_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: each accepted word owns the edge window [start, end]; bit j shows after edge start+j.
    logic [DW-1:0] m_data  [1024];
    int            m_push  [1024];
    int            m_start [1024];
    int            m_end   [1024];
    bit            m_live  [1024];
    int            m_n      = 0;
    int            last_end = 0;

    function automatic int exp_count(int e);
        int c = 0;
        for (int i = 0; i < m_n; i++)
            if (m_live[i] && m_push[i] <= e && m_start[i] > e) c++;
        return c;
    endfunction

    function automatic logic [CW+2:0] exp_vec(int e);
        logic so   = 1'b0;
        logic act  = 1'b0;
        logic done = 1'b0;
        for (int i = 0; i < m_n; i++) begin
            if (m_live[i] && m_start[i] <= e && e <= m_end[i]) begin
                act  = 1'b1;
                so   = m_data[i][DW-1-(e-m_start[i])];
                done = (e == m_start[i] + DW - 1);
            end
        end
        return {so, act, done, CW'(exp_count(e))};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < m_n; i++) m_live[i] = 1'b0;
        last_end = cyc;
    endfunction

    function automatic void model_flush(int f);
        for (int i = 0; i < m_n; i++) begin
            if (m_live[i]) begin
                if (m_start[i] >= f) m_live[i] = 1'b0;
                else if (m_end[i] >= f) m_end[i] = f - 1;
            end
        end
        last_end = f;
    endfunction

    task automatic step();
        int e = cyc + 1;
        if (n_rst && !flush && load_valid && exp_count(cyc) < DEPTH) begin
            m_data[m_n]  = load_data;
            m_push[m_n]  = e;
            m_start[m_n] = (e + 1 > last_end + 1) ? e + 1 : last_end + 1;
            m_end[m_n]   = m_start[m_n] + DW - 1;
            m_live[m_n]  = 1'b1;
            last_end     = m_end[m_n];
            m_n++;
        end
        if (n_rst && flush) model_flush(e);
        @(posedge tb_clk);
        cyc++;
        @(negedge tb_clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b1; load_valid = 1'b0; flush = 1'b0; load_data = '0;
        l_load_valid = 1'b0; l_flush = 1'b0; l_load_data = '0;
        #1 n_rst = 1'b0;
        #1;
        checks++;
        if ({serial_out, serial_active, word_done, fifo_count} !== '0) begin
            failures++;
            $display("FAIL reset_init got=%b exp=0", {serial_out, serial_active, word_done, fifo_count});
        end
        repeat (2) step();
        n_rst = 1'b1;
        #1;
        checks++;
        if ({serial_out, serial_active, word_done, fifo_count} !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", {serial_out, serial_active, word_done, fifo_count}, exp_vec(cyc));
        end
        load_data = 8'hFF; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (4) begin
            step();
            checks++;
            if ({serial_out, serial_active, word_done, fifo_count} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL reset_preword cyc=%0d got=%b exp=%b", cyc, {serial_out, serial_active, word_done, fifo_count}, exp_vec(cyc));
            end
        end
        #2 n_rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({serial_out, serial_active, word_done, fifo_count} !== '0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=0", {serial_out, serial_active, word_done, fifo_count});
        end
        step();
        n_rst = 1'b1;
        repeat (3) begin
            #1;
            checks++;
            if ({serial_out, serial_active, word_done, fifo_count} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, {serial_out, serial_active, word_done, fifo_count}, exp_vec(cyc));
            end
            step();
        end
    endtask

    task automatic test_single_word();
        logic [3:0] hist = '0;
        int hits  = 0;
        int dones = 0;
        load_data = 8'b1101_0000; load_valid = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%b exp=1", load_ready);
        end
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            hist = {hist[2:0], serial_out};
            if (hist == 4'b1101) hits++;
            if (word_done) dones++;
            checks++;
            if ({serial_out, serial_active, word_done, fifo_count} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, {serial_out, serial_active, word_done, fifo_count}, exp_vec(cyc));
            end
        end
        checks++;
        if (hits !== 1 || dones !== 1) begin
            failures++;
            $display("FAIL single_detect hits=%0d dones=%0d exp=1/1", hits, dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [3];
        int peak = 0, act_cycles = 0, dones = 0;
        words[0] = 8'hD0; words[1] = 8'hDD; words[2] = 8'h0D;
        for (int i = 0; i < 33; i++) begin
            load_valid = (i < 3);
            load_data  = (i < 3) ? words[i] : '0;
            #1;
            checks++;
            if (load_ready !== ((exp_count(cyc) < DEPTH) && !flush)) begin
                failures++;
                $display("FAIL b2b_ready cyc=%0d got=%b", cyc, load_ready);
            end
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (serial_active) act_cycles++;
            if (word_done) dones++;
            checks++;
            if ({serial_out, serial_active, word_done, fifo_count} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, {serial_out, serial_active, word_done, fifo_count}, exp_vec(cyc));
            end
        end
        checks++;
        if (peak !== 2 || act_cycles !== 24 || dones !== 3) begin
            failures++;
            $display("FAIL b2b_summary peak=%0d active=%0d dones=%0d exp=2/24/3", peak, act_cycles, dones);
        end
    endtask

    task automatic test_full_fifo();
        int rej = 0;
        for (int i = 0; i < 60; i++) begin
            load_valid = (i < 7);
            load_data  = DW'($urandom);
            #1;
            if (load_valid && !load_ready) rej++;
            checks++;
            if (load_ready !== ((exp_count(cyc) < DEPTH) && !flush)) begin
                failures++;
                $display("FAIL full_ready cyc=%0d got=%b", cyc, load_ready);
            end
            step();
            checks++;
            if ({serial_out, serial_active, word_done, fifo_count} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL full cyc=%0d got=%b exp=%b", cyc, {serial_out, serial_active, word_done, fifo_count}, exp_vec(cyc));
            end
        end
        load_valid = 1'b0;
        checks++;
        if (rej !== 2) begin
            failures++;
            $display("FAIL full_rejects got=%0d exp=2", rej);
        end
    endtask

    task automatic test_flush();
        int dones = 0;
        for (int i = 0; i < 20; i++) begin
            load_valid = (i < 3);
            load_data  = (i == 0) ? 8'hFF : DW'($urandom);
            flush      = (i == 4);
            #1;
            checks++;
            if (load_ready !== ((exp_count(cyc) < DEPTH) && !flush)) begin
                failures++;
                $display("FAIL flush_ready cyc=%0d got=%b", cyc, load_ready);
            end
            step();
            if (i >= 4 && word_done) dones++;
            checks++;
            if ({serial_out, serial_active, word_done, fifo_count} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL flush cyc=%0d got=%b exp=%b", cyc, {serial_out, serial_active, word_done, fifo_count}, exp_vec(cyc));
            end
        end
        flush = 1'b0;
        load_valid = 1'b0;
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL flush_done got=%0d exp=0", dones);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 360; i++) begin
            load_valid = (i < 300) && ($urandom_range(0, 3) != 0);
            flush      = (i < 300) && ($urandom_range(0, 40) == 0);
            load_data  = DW'($urandom);
            #1;
            checks++;
            if (load_ready !== ((exp_count(cyc) < DEPTH) && !flush)) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%b", cyc, load_ready);
            end
            step();
            checks++;
            if ({serial_out, serial_active, word_done, fifo_count} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL rand cyc=%0d got=%b exp=%b", cyc, {serial_out, serial_active, word_done, fifo_count}, exp_vec(cyc));
            end
        end
        load_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq = 8'b1101_0000;
        l_load_data = 8'b0000_1011; l_load_valid = 1'b1;
        step();
        l_load_valid = 1'b0;
        step();
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (j < 8) begin
                if ({l_serial_out, l_serial_active, l_word_done} !== {seq[7-j], 1'b1, (j == 7)}) begin
                    failures++;
                    $display("FAIL lsb bit=%0d got=%b exp=%b", j, {l_serial_out, l_serial_active, l_word_done}, {seq[7-j], 1'b1, (j == 7)});
                end
            end else if ({l_serial_out, l_serial_active, l_word_done} !== 3'b000) begin
                failures++;
                $display("FAIL lsb_idle step=%0d got=%b exp=000", j, {l_serial_out, l_serial_active, l_word_done});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_full_fifo();
        test_flush();
        test_random();
        test_lsb_first();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_feeder.md
# serial_feeder

Upstream stimulus stage for the bit-serial sequence detector. It accepts parallel words through a valid/ready handshake and buffers them in a small FIFO. It shifts each word out one bit per clock on `serial_out`, which drives the detector's single-bit `i` input directly. Words stream back-to-back with no gap bits, and a defined idle value is driven whenever no data is pending.

## Interface
- `DATA_WIDTH`, default 8: bits per word; legal range 2..32.
- `DEPTH`, default 4: FIFO entries; power of two, legal range 2..16.
- `MSB_FIRST`, default 1: 1 shifts bit `DATA_WIDTH-1` out first; 0 shifts bit 0 out first.
- `IDLE_VALUE`, default 1'b0: level driven on `serial_out` when no word is being shifted.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `load_data`  in  `DATA_WIDTH`  word to enqueue.
- `load_valid`  in  1  `load_data` is valid this cycle.
- `load_ready`  out  1  FIFO can accept a word; equals `(fifo_count < DEPTH) && !flush`; combinational from registered count.
- `flush`  in  1  synchronous clear of the FIFO and of the word currently shifting.
- `serial_out`  out  1  registered serial bit stream to the detector.
- `serial_active`  out  1  registered; high while `serial_out` carries a data bit.
- `word_done`  out  1  registered; one-cycle pulse coincident with the last bit of each word on `serial_out`.
- `fifo_count`  out  $clog2(DEPTH+1)  number of buffered words, excluding the word in the shifter.

## Operation
**Push**
- A push occurs at an edge where `load_valid && load_ready`.
- Pushes while `n_rst` is low, or while `flush` is high, are discarded.

**FIFO**
- Circular buffer with read and write pointers of width $clog2(DEPTH); pointers wrap at DEPTH.
- `fifo_count` is an explicit counter.
- A simultaneous push and pop leaves the count unchanged.
- No overflow is possible, because `load_ready` is low when full.
- A pop from an empty FIFO never occurs.

**Shifter FSM**
- Two states, IDLE and SHIFT. Contents: shift register of `DATA_WIDTH` bits and a bit counter of $clog2(DATA_WIDTH) bits.
- IDLE, `fifo_count > 0` at the edge: pop the head word into the shifter, set the bit counter to 0, go to SHIFT. `serial_out` takes the first bit (MSB or LSB per `MSB_FIRST`).
- IDLE, `fifo_count == 0`: stay in IDLE. `serial_out = IDLE_VALUE`, `serial_active = 0`.
- SHIFT, bit counter below `DATA_WIDTH-1`: advance one bit per edge and increment the counter.
- SHIFT, bit counter at `DATA_WIDTH-1` (last bit showing, `word_done` high):
  - If `fifo_count > 0` at the edge, pop the next word and present its first bit at the next cycle. No gap, and `serial_active` stays high.
  - Otherwise go to IDLE and drive `IDLE_VALUE`.
- Pop eligibility uses the pre-edge `fifo_count`. A word pushed into an empty FIFO at edge k is poppable at edge k+1 at the earliest.

**Flush**
- At an edge with `flush` high: count goes to 0, pointers to 0, FSM to IDLE.
- After that edge: `serial_out = IDLE_VALUE`, `serial_active = 0`, `word_done = 0`.
- A partially shifted word is dropped.

**Reset**
- `n_rst` low asynchronously clears the FSM to IDLE, pointers and count to 0, `serial_out` to `IDLE_VALUE`, and `serial_active` and `word_done` to 0.
- FIFO storage contents need not be reset.
- Reset mid-word aborts the word immediately, without waiting for a clock.

## Timing
- Push at edge k into an empty FIFO with the shifter IDLE:
  - pop at edge k+1;
  - bit j of the word appears on `serial_out` in the cycle after edge k+1+j, for j = 0..DATA_WIDTH-1;
  - `word_done` is high in the cycle after edge k+DATA_WIDTH.
- Continuous streaming: a sustained rate of one word per `DATA_WIDTH` cycles gives zero idle bits between words.
- `load_ready` depends only on the registered count and `flush`; it has no combinational path from `load_valid`.
- All outputs except `load_ready` change only on a rising edge or on asynchronous reset assertion.

## Test plan
1. **Reset.** Drive `n_rst` = 0 mid-simulation → `serial_out` = `IDLE_VALUE` (0), `serial_active` = 0, `word_done` = 0, `fifo_count` = 0, all within the same timestep. Release `n_rst` on a negedge → outputs hold.
2. **Single word, MSB first.** Push 8'b1101_0000 at edge k → `serial_out` = 1,1,0,1,0,0,0,0 after edges k+1..k+8; `word_done` high only after edge k+8; then idle 0. A downstream 1101 detector fires once.
3. **Back-to-back.** Push 8'hD0, 8'hDD, 8'h0D on consecutive cycles → 24 contiguous data bits with `serial_active` high throughout; `word_done` pulses at bits 8, 16 and 24; `fifo_count` peaks at 2.
4. **Full FIFO.** Stall the shifter's drain by pushing 5 words rapidly with DEPTH = 4 → `load_ready` drops when `fifo_count` = 4, a push with `load_ready` low is not stored, and `load_ready` returns to 1 at the next pop.
5. **Flush mid-word.** Assert `flush` for one cycle after 3 bits of 8'hFF with 2 words queued → `serial_out` = 0 and `fifo_count` = 0 the next cycle, and no further `word_done` pulses.
6. **LSB first.** Set `MSB_FIRST` = 0 and push 8'b0000_1011 → `serial_out` = 1,1,0,1,0,0,0,0.
